// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional header packet format is selected by the UART_ARB_HEADER_EN macro.
package uart_arb_pkg;

    localparam int         GID_W      = 4;
    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] HDR_TAG    = 4'hA;

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_SEND = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first asserted request at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GID_W-1:0]   grant_idx,
    output logic               grant_any
);

    int best_d;
    int d;

    // Smallest wrap-around distance from ptr wins among asserted requests.
    always_comb begin
        best_d    = NUM_REQ;
        d         = 0;
        grant_idx = '0;
        grant_any = 1'b0;
        grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
            if (req[i] && d < best_d) begin
                best_d    = d;
                grant_idx = GID_W'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_any && (grant_idx == GID_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises 32-bit words from NUM_REQ requesters
// into a byte stream for a UART transmitter.
// Define UART_ARB_HEADER_EN to prefix each packet with {HDR_TAG, grant_id}.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter bit BYTE_ORDER_MSB = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_data_ready,
    output logic [GID_W-1:0]      grant_id,
    output logic                  busy
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    state_t             state_q, state_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [31:0]        sh_q, sh_d;
    logic [GID_W-1:0]   gid_q, gid_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [GID_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [31:0]        gnt_word;
    logic               xfer;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    // One-hot mux of the granted requester's word.
    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) gnt_word = req_data[32*i +: 32];
        end
    end

    // Valid/busy come straight from state so they never see tx_data_ready.
    assign tx_data_valid = (state_q != S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign grant_id      = gid_q;
    assign xfer          = tx_data_valid && tx_data_ready;

    // Output byte: header in HDR, otherwise the head of the shift register.
    always_comb begin
        tx_data = BYTE_ORDER_MSB ? sh_q[31:24] : sh_q[7:0];
`ifdef UART_ARB_HEADER_EN
        if (state_q == S_HDR) tx_data = {HDR_TAG, gid_q};
`endif
    end

    // Next-state logic: grant in IDLE, then walk the bytes on each transfer.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        gid_d     = gid_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    // Gated by rst so no acknowledge leaks out while in reset.
                    req_ready = rst ? '0 : gnt_oh;
                    sh_d      = gnt_word;
                    gid_d     = gnt_idx;
                    cnt_d     = 2'd0;
                    rr_ptr_d  = (gnt_idx == GID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef UART_ARB_HEADER_EN
                    state_d   = S_HDR;
`else
                    state_d   = S_SEND;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            S_HDR: begin
                if (xfer) state_d = S_SEND;
            end
`endif
            S_SEND: begin
                if (xfer) begin
                    sh_d  = BYTE_ORDER_MSB ? {sh_q[23:0], 8'h00} : {8'h00, sh_q[31:8]};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BYTE) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            gid_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            gid_q    <= gid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, MSB-first).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
`ifdef UART_ARB_HEADER_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int HOFF = NB - 4;

    logic                  sys_clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            tx_data;
    logic                  tx_data_valid;
    logic                  tx_data_ready;
    logic [3:0]            grant_id;
    logic                  busy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BYTE_ORDER_MSB(1'b1)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".tx_data"},   32'(tx_data),       32'h0);
        chk({tag, ".tx_valid"},  32'(tx_data_valid), 32'h0);
        chk({tag, ".req_ready"}, 32'(req_ready),     32'h0);
        chk({tag, ".grant_id"},  32'(grant_id),      32'h0);
        chk({tag, ".busy"},      32'(busy),          32'h0);
    endtask

    function automatic logic [7:0] data_byte(input logic [31:0] w, input int idx);
        logic [31:0] s;
        s = w >> (8 * (3 - idx));
        return s[7:0];
    endfunction

    // Entered at a negedge where the first byte must already be valid.
    // Follows the packet to its end and checks the 1-cycle IDLE gap.
    task automatic collect(input string tag, input logic [3:0] gid, input logic [31:0] w,
                           input bit toggle, input int change_at, input logic [3:0] new_valid);
        int   k;
        int   cyc;
        logic xf;
        logic [7:0] eb;
        k   = 0;
        cyc = 0;
        tx_data_ready = toggle ? 1'b0 : 1'b1;
        while (k < NB && cyc < 64) begin
            #1;
            eb = (HOFF == 1 && k == 0) ? {4'hA, gid} : data_byte(w, k - HOFF);
            chk({tag, ".valid"},     32'(tx_data_valid), 32'h1);
            chk({tag, ".busy"},      32'(busy),          32'h1);
            chk({tag, ".grant_id"},  32'(grant_id),      32'(gid));
            chk({tag, ".req_ready"}, 32'(req_ready),     32'h0);
            chk({tag, ".byte"},      32'(tx_data),       32'(eb));
            if (cyc == change_at) req_valid = new_valid;
            xf = tx_data_ready;
            @(negedge sys_clk);
            if (xf) k++;
            cyc++;
            if (toggle) tx_data_ready = ~tx_data_ready;
        end
        if (k < NB) chk({tag, ".timeout"}, 32'(k), 32'(NB));
        tx_data_ready = 1'b1;
        #1;
        chk({tag, ".gap_valid"}, 32'(tx_data_valid), 32'h0);
        chk({tag, ".gap_busy"},  32'(busy),          32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w4 [4];
        w4[0] = 32'h10111213; w4[1] = 32'h20212223;
        w4[2] = 32'h30313233; w4[3] = 32'h40414243;

        // Reset with requests pending: everything must stay quiet.
        rst = 1'b1; req_valid = 4'b1111; req_data = '0; tx_data_ready = 1'b1;
        @(negedge sys_clk); @(negedge sys_clk); #1;
        chk_zero("reset");

        // Single requester 1, DEADBEEF, ready high; first edge after release grants.
        @(negedge sys_clk);
        rst = 1'b0; req_valid = 4'b0010; req_data[32*1 +: 32] = 32'hDEADBEEF;
        #1 chk("t1.req_ready", 32'(req_ready), 32'b0010);
        @(negedge sys_clk);
        collect("t1", 4'd1, 32'hDEADBEEF, 1'b0, 0, 4'b0000);
        chk("t1.no_regrant", 32'(req_ready), 32'h0);

        // All four valid continuously: grants 0,1,2,3,0 with 1-cycle gaps.
        rst = 1'b1; #1;
        chk_zero("t2.rst");
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = w4[i];
        req_valid = 4'b1111;
        @(negedge sys_clk);
        rst = 1'b0;
        #1;
        for (int p = 0; p < 5; p++) begin
            chk("t2.req_ready", 32'(req_ready), 32'(4'b0001 << (p % 4)));
            @(negedge sys_clk);
            collect("t2", 4'(p % 4), w4[p % 4], 1'b0, -1, 4'b0000);
        end
        req_valid = 4'b0000;

        // Requester 1 served (pointer now 1) while 0 waits, then 0 drops mid-packet.
        req_valid = 4'b0011; req_data[32*1 +: 32] = 32'hCAFEF00D;
        #1 chk("t4.req_ready", 32'(req_ready), 32'b0010);
        @(negedge sys_clk);
        collect("t4", 4'd1, 32'hCAFEF00D, 1'b0, 1, 4'b0000);
        chk("t4.no_req0", 32'(req_ready), 32'h0);

        // Toggling ready: each byte must hold across the stall cycle.
        req_valid = 4'b1000; req_data[32*3 +: 32] = 32'h01020304;
        #1 chk("t5.req_ready", 32'(req_ready), 32'b1000);
        @(negedge sys_clk);
        collect("t5", 4'd3, 32'h01020304, 1'b1, 0, 4'b0000);

        // Requester 3 with 11223344 (header build prefixes A3).
        req_valid = 4'b1000; req_data[32*3 +: 32] = 32'h11223344;
        #1 chk("t6.req_ready", 32'(req_ready), 32'b1000);
        @(negedge sys_clk);
        collect("t6", 4'd3, 32'h11223344, 1'b0, 0, 4'b0000);

        // Reset after two bytes of a packet: outputs clear asynchronously.
        req_valid = 4'b0010; req_data[32*1 +: 32] = 32'hDEADBEEF;
        #1 chk("t7.req_ready", 32'(req_ready), 32'b0010);
        @(negedge sys_clk);
        req_valid = 4'b0000;
        @(negedge sys_clk); @(negedge sys_clk);
        #1 chk("t7.third_byte", 32'(tx_data), 32'(HOFF == 1 ? 8'hAD : 8'hBE));
        #1 rst = 1'b1;
        #1 chk_zero("t7.async");
        req_valid = 4'b0100; req_data[32*2 +: 32] = 32'h55667788;
        @(negedge sys_clk); #1;
        chk("t7.rr_in_rst", 32'(req_ready), 32'h0);
        @(negedge sys_clk);
        rst = 1'b0;
        #1 chk("t7.req_ready", 32'(req_ready), 32'b0100);
        @(negedge sys_clk);
        collect("t7", 4'd2, 32'h55667788, 1'b0, 0, 4'b0000);

        // After reset the pointer restarts at 0: requester 0 beats 2.
        rst = 1'b1; req_valid = 4'b0101; req_data[32*0 +: 32] = 32'hA0A1A2A3;
        #1 chk_zero("t8.rst");
        @(negedge sys_clk);
        rst = 1'b0;
        #1 chk("t8.first", 32'(req_ready), 32'b0001);
        @(negedge sys_clk);
        collect("t8a", 4'd0, 32'hA0A1A2A3, 1'b0, -1, 4'b0000);
        chk("t8.second", 32'(req_ready), 32'b0100);
        @(negedge sys_clk);
        collect("t8b", 4'd2, 32'h55667788, 1'b0, 0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of 32-bit word requesters (legal range 2..16).
REQ-002 The block SHALL have parameter BYTE_ORDER_MSB, default 1: 1 sends byte[31:24] first, 0 sends byte[7:0] first.
REQ-003 Port sys_clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ  per-requester word-valid flags.
REQ-006 Port req_data  input  32*NUM_REQ  packed words; requester i occupies bits [32*i+31:32*i].
REQ-007 Port req_ready  output  NUM_REQ  one-hot, one-cycle acknowledge; the word is consumed in the same cycle.
REQ-008 Port tx_data  output  8  byte to the UART transmitter.
REQ-009 Port tx_data_valid  output  1  tx_data is valid.
REQ-010 Port tx_data_ready  input  1  transmitter accepts; a byte transfers when tx_data_valid and tx_data_ready are both high.
REQ-011 Port grant_id  output  4  index of the requester being served; holds its value while busy.
REQ-012 Port busy  output  1  high from grant until the last byte of the packet transfers.

Function
REQ-013 States SHALL be IDLE, HDR and SEND. HDR exists only under configuration (REQ-027).
REQ-014 IDLE, no req_valid: remain in IDLE; tx_data_valid=0; req_ready=0.
REQ-015 IDLE, any req_valid: a round-robin grant SHALL select the first requester at or after pointer rr_ptr (wrapping NUM_REQ-1 to 0).
  - req_ready[grant] pulses for 1 cycle.
  - The word is latched into a 32-bit shift register.
  - grant_id and busy update in the next cycle.
REQ-016 After a grant, rr_ptr SHALL become grant+1 modulo NUM_REQ. A requester continuously asserting req_valid SHALL therefore never be served twice in a row while another requester is valid.
REQ-017 The first byte SHALL present tx_data_valid=1 in the cycle after the grant (1-cycle latency).
REQ-018 SEND SHALL transmit 4 bytes in BYTE_ORDER_MSB order under a 2-bit byte counter.
  - tx_data stays stable while tx_data_valid=1 and tx_data_ready=0.
  - The counter advances only on a transfer.
REQ-019 On transfer of byte 3, the FSM SHALL return to IDLE and busy SHALL drop in the next cycle. A new grant is allowed in that IDLE cycle, so back-to-back packets have a 1-cycle gap of tx_data_valid=0.
REQ-020 req_valid changes during a packet SHALL have no effect until IDLE.
REQ-021 tx_data_ready held low indefinitely SHALL stall the FSM with no data loss and no req_ready pulses.
REQ-022 tx_data_valid SHALL never depend combinationally on tx_data_ready.

Reset
REQ-023 When rst is asserted, all state SHALL clear asynchronously:
  - FSM goes to IDLE.
  - rr_ptr=0, byte counter=0, shift register=0.
  - tx_data=0, tx_data_valid=0, req_ready=0, grant_id=0, busy=0.
REQ-024 Reset mid-packet SHALL abandon the packet silently. Remaining bytes are never sent, and the first grant after reset starts at requester 0.
REQ-025 On rst deassertion, the earliest req_ready pulse SHALL occur on the first sys_clk edge with rst low.

Configuration
REQ-026 Macro UART_ARB_HEADER_EN SHALL select the packet format.
REQ-027 With UART_ARB_HEADER_EN defined: after the grant, the FSM SHALL enter HDR and send header byte {4'hA, grant_id} before SEND.
  - Packet length is 5 bytes.
  - First-byte latency stays at 1 cycle.
REQ-028 Without UART_ARB_HEADER_EN: HDR and its logic SHALL be absent, and packets SHALL be 4 bytes.

Structure
REQ-029 Package uart_arb_pkg SHALL hold the FSM state enum, HDR_TAG=4'hA, WORD_BYTES=4 and the grant_id width constant.
REQ-030 Sub-module rr_arbiter SHALL contain the combinational round-robin priority selection.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and index.
  - Parameterised by NUM_REQ.

Verification
REQ-031 Single requester 1 sends 32'hDEADBEEF, ready tied high, BYTE_ORDER_MSB=1 -> bytes DE, AD, BE, EF on 4 consecutive cycles; req_ready[1] pulses once; grant_id=1.
REQ-032 All 4 requesters valid continuously -> grants in order 0,1,2,3,0; 4-cycle bytes; 1-cycle IDLE gap between packets.
REQ-033 tx_data_ready toggling 1/0 each cycle with word 32'h01020304 -> each byte held stable while stalled; output 01, 02, 03, 04; busy high throughout.
REQ-034 rst asserted after the 2nd byte of a packet -> all outputs 0 asynchronously; after release, requester 2 valid alone -> its full packet is sent; requester 0 is served before 2 when both are valid.
REQ-035 UART_ARB_HEADER_EN defined, requester 3 sends 32'h11223344 -> bytes A3, 11, 22, 33, 44.
REQ-036 Requester 0 deasserts req_valid mid-packet of requester 1 -> no req_ready[0] pulse; requester 1's packet completes intact.
